// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a valid/ready handshake, a one-entry skid buffer and a synchronous flush.
// Define MEMWB_FWD_EN to add the fwd_en/fwd_rn/fwd_data forwarding ports, driven from the output register.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mwregin,
  input  logic              mm2regin,
  input  logic              mwmemin,
  input  logic [DATA_W-1:0] maluin,
  input  logic [RN_W-1:0]   mrnin,
  input  logic [DATA_W-1:0] diin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [DATA_W-1:0] malu,
  output logic [RN_W-1:0]   mrn,
  output logic [DATA_W-1:0] di
`ifdef MEMWB_FWD_EN
  ,
  output logic              fwd_en,
  output logic [RN_W-1:0]   fwd_rn,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [DATA_W-1:0] alu;
    logic [RN_W-1:0]   rn;
    logic [DATA_W-1:0] di;
  } beat_t;

  beat_t in_beat;
  beat_t o_q;
  beat_t s_q;
  logic  o_v;
  logic  s_v;
  logic  in_xfer;
  logic  o_load;

  assign in_beat = {mwregin, mm2regin, mwmemin, maluin, mrnin, diin};

  // in_ready comes straight from the skid flag, so it has no path from in_valid or out_ready.
  assign in_ready = !s_v;
  assign in_xfer  = in_valid && !s_v;
  assign o_load   = !o_v || out_ready;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
    if (rst) begin
      // NOTE: the data fields are reset as well, so the outputs read zero after reset rather than stale contents.
      o_v <= 1'b0;
      s_v <= 1'b0;
      o_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
    end else if (o_load) begin
      // The skid entry is older than anything arriving now, so it drains first.
      if (s_v) begin
        o_q <= s_q;
        o_v <= 1'b1;
        s_v <= in_xfer;
        if (in_xfer) s_q <= in_beat;
      end else begin
        o_v <= in_xfer;
        if (in_xfer) o_q <= in_beat;
      end
    end else if (in_xfer) begin
      s_q <= in_beat;
      s_v <= 1'b1;
    end
  end

  // Write-side controls are gated so a bubble never writes the register file or memory.
  assign out_valid = o_v;
  assign mwreg     = o_q.wreg  && o_v;
  assign mm2reg    = o_q.m2reg && o_v;
  assign mwmem     = o_q.wmem  && o_v;
  assign malu      = o_q.alu;
  assign mrn       = o_q.rn;
  assign di        = o_q.di;

`ifdef MEMWB_FWD_EN
  assign fwd_en   = o_v && o_q.wreg && (o_q.rn != '0);
  assign fwd_rn   = o_q.rn;
  assign fwd_data = o_q.m2reg ? o_q.di : o_q.alu;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: the stage is modelled as an ordered queue of at most two accepted beats.
// A monitor on the falling edge compares the DUT outputs with the head of that queue.
module tb_mem_wb_pipe;

  typedef struct {
    bit        wreg;
    bit        m2reg;
    bit        wmem;
    bit [31:0] alu;
    bit [4:0]  rn;
    bit [31:0] di;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mwregin = 1'b0;
  logic        mm2regin = 1'b0;
  logic        mwmemin = 1'b0;
  logic [31:0] maluin = '0;
  logic [4:0]  mrnin = '0;
  logic [31:0] diin = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [4:0]  mrn;
  logic [31:0] di;
`ifdef MEMWB_FWD_EN
  logic        fwd_en;
  logic [4:0]  fwd_rn;
  logic [31:0] fwd_data;
`endif

  mem_wb_pipe #(.DATA_W(32), .RN_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mwregin(mwregin), .mm2regin(mm2regin), .mwmemin(mwmemin),
    .maluin(maluin), .mrnin(mrnin), .diin(diin),
    .out_valid(out_valid), .out_ready(out_ready),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mrn(mrn), .di(di)
`ifdef MEMWB_FWD_EN
    , .fwd_en(fwd_en), .fwd_rn(fwd_rn), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  function automatic beat_t mk(input bit [31:0] alu, input bit [4:0] rn, input bit wreg,
                               input bit m2reg, input bit wmem, input bit [31:0] d);
    beat_t b;
    b.alu = alu; b.rn = rn; b.wreg = wreg; b.m2reg = m2reg; b.wmem = wmem; b.di = d;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    return mk($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
  endfunction

  // One clock cycle: drive after the rising edge, update the reference queue after the monitor has run.
  task automatic cycle(input bit v, input beat_t b, input bit ordy, input bit fl = 1'b0, input bit r = 1'b0);
    bit acc;
    @(posedge clk);
    #1;
    rst = r; flush = fl; in_valid = v; out_ready = ordy;
    mwregin = b.wreg; mm2regin = b.m2reg; mwmemin = b.wmem;
    maluin = b.alu; mrnin = b.rn; diin = b.di;
    acc = v && !r && !fl && (exp_q.size() < 2);
    @(negedge clk);
    #1;
    if (r || fl) exp_q.delete();
    else if (acc) exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 80'(out_valid), 80'(exp_q.size() > 0));
      check("in_ready", 80'(in_ready), 80'(exp_q.size() < 2));
      if (!out_valid) begin
        check("bubble_ctrl", 80'({mwreg, mm2reg, mwmem}), 80'(0));
`ifdef MEMWB_FWD_EN
        check("fwd_en_bubble", 80'(fwd_en), 80'(0));
`endif
      end else if (exp_q.size() > 0) begin
        beat_t e;
        e = exp_q[0];
        check("beat", {8'h0, mwreg, mm2reg, mwmem, malu, mrn, di},
              {8'h0, e.wreg, e.m2reg, e.wmem, e.alu, e.rn, e.di});
`ifdef MEMWB_FWD_EN
        check("fwd_en", 80'(fwd_en), 80'(e.wreg && e.rn != 0));
        check("fwd_rn", 80'(fwd_rn), 80'(e.rn));
        check("fwd_data", 80'(fwd_data), 80'(e.m2reg ? e.di : e.alu));
`endif
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  beat_t idle;
  beat_t ba, bb, bc;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0);

    // Reset with random inputs, then confirm every output is cleared.
    cycle(1'b1, rnd_beat(), 1'b1, 1'b0, 1'b1);
    cycle(1'b1, rnd_beat(), 1'b0, 1'b1, 1'b1);
    cycle(1'b0, idle, 1'b1);
    check("rst_data", {8'h0, out_valid, in_ready, mwreg, malu, mrn, di},
          {8'h0, 1'b0, 1'b1, 1'b0, 32'h0, 5'h0, 32'h0});
    check("rst_ctrl", 80'({mm2reg, mwmem}), 80'(0));

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) cycle(1'b1, mk(32'h11 * i, 5'(i), 1'b1, 1'b0, 1'b0, 32'h100 + i), 1'b1);
    cycle(1'b0, idle, 1'b1);
    cycle(1'b0, idle, 1'b1);

    // Skid: out_ready drops while B is presented; C waits for room.
    ba = mk(32'hA, 5'd10, 1'b1, 1'b0, 1'b0, 32'hA0);
    bb = mk(32'hB, 5'd11, 1'b1, 1'b1, 1'b0, 32'hB0);
    bc = mk(32'hC, 5'd12, 1'b0, 1'b0, 1'b1, 32'hC0);
    cycle(1'b1, ba, 1'b1);
    cycle(1'b1, bb, 1'b0);
    cycle(1'b1, bc, 1'b0);
    cycle(1'b1, bc, 1'b0);
    cycle(1'b1, bc, 1'b1);
    cycle(1'b1, bc, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b1);

    // Flush with both entries full and a beat on the input.
    cycle(1'b1, rnd_beat(), 1'b0);
    cycle(1'b1, rnd_beat(), 1'b0);
    cycle(1'b1, mk(32'hDEAD, 5'd9, 1'b1, 1'b0, 1'b1, 32'hBAD), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, idle, 1'b1);

    // Bubbles carrying write enables must not write.
    for (int i = 0; i < 4; i++) cycle(1'b0, mk($urandom, 5'($urandom), 1'b1, 1'b1, 1'b1, $urandom), 1'($urandom));

    // Forwarding candidates: r0 never forwards, a load to r7 forwards its memory data.
    cycle(1'b1, mk(32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 32'h66), 1'b1);
    cycle(1'b1, mk(32'h77, 5'd7, 1'b1, 1'b1, 1'b0, 32'hCAFE), 1'b1);
    cycle(1'b0, idle, 1'b1);
    cycle(1'b0, idle, 1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      bit r, fl;
      r  = ($urandom_range(99) == 0);
      fl = ($urandom_range(99) < 4);
      cycle(1'($urandom_range(3) != 0), rnd_beat(), 1'($urandom_range(9) < 6), fl, r);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, idle, 1'b1);
    check("drained", 80'(exp_q.size()), 80'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline register that supersedes the fixed 32-bit, always-load stage register between the memory stage and write-back. It adds a valid/ready handshake with a one-entry skid buffer for write-back backpressure, a synchronous flush, and configurable data and register-number widths. Write-side control outputs are qualified by valid, so a bubble can never write the register file or memory.

## Interface
Parameters:
- DATA_W, 32, width of ALU result and memory read data
- RN_W, 5, width of destination register number

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming beats this cycle
- in_valid  in  1  MEM stage presents a beat
- in_ready  out  1  stage can accept a beat; registered, depends only on skid occupancy
- mwregin  in  1  register-write enable of incoming beat
- mm2regin  in  1  select memory data for write-back
- mwmemin  in  1  memory-write flag of incoming beat
- maluin  in  DATA_W  ALU result
- mrnin  in  RN_W  destination register number
- diin  in  DATA_W  memory read data
- out_valid  out  1  output register holds a valid beat
- out_ready  in  1  WB consumes the output beat
- mwreg, mm2reg, mwmem  out  1 each  stored controls ANDed with out_valid
- malu  out  DATA_W  stored ALU result
- mrn  out  RN_W  stored destination
- di  out  DATA_W  stored memory data

## Operation
- Storage: output register (O) with o_v, and skid register (S) with s_v.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready = !s_v.
- O loads when O is empty or consumed this cycle. Source priority: S first, then the input.
- If O loads from S and an input transfers in the same cycle, the input goes to S. s_v stays 1 and in_ready stays 0 the next cycle.
- If an input transfers while O is held (o_v & !out_ready), the input goes to S.
- Order is strictly FIFO. Maximum occupancy is 2 beats; no beat is dropped or duplicated.
- flush: o_v ← 0, s_v ← 0, and any input transfer this cycle is discarded. Data fields keep their values.
- rst has priority over flush. It clears o_v and s_v and zeroes every data field.
- Data outputs hold their last value while out_valid = 0. The control outputs read 0 while out_valid = 0.

## Timing
- Reset values: out_valid=0, in_ready=1, mwreg=mm2reg=mwmem=0, malu=0, mrn=0, di=0.
- Latency: an input accepted at edge N is visible at the outputs after edge N (out_valid=1 in cycle N+1).
- Throughput: 1 beat/cycle while out_ready=1; S stays empty.
- Backpressure: out_ready falling while in_valid=1 lets one more beat into S. in_ready drops the cycle after.
- Recovery: with S full, out_ready=1 moves S→O and reasserts in_ready after the same edge.
- Reset or flush mid-stall: both entries are empty after the edge and in_ready=1 the following cycle.
- No combinational path from out_ready or in_valid to in_ready.

## Configuration
- MEMWB_FWD_EN defined adds ports:
  - fwd_en (1): out_valid & mwreg & (mrn != 0)
  - fwd_rn (RN_W): equal to mrn
  - fwd_data (DATA_W): mm2reg ? di : malu
- All three are combinational from O, for the ID-stage forwarding unit.
- MEMWB_FWD_EN undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, in_ready=1, out_valid=0.
- Streaming: out_ready=1, 4 beats with maluin=0x11..0x44 and mrnin=1..4 on consecutive cycles -> each appears exactly one cycle later, in order, with in_ready constantly 1.
- Skid: stream beats A,B,C and drop out_ready while B is presented -> A held, B captured in S, in_ready=0. Raise out_ready 3 cycles later -> outputs A,B,C in order with no loss.
- Flush: with O and S full, assert flush together with in_valid=1 -> next cycle out_valid=0, mwreg=mwmem=0, in_ready=1, and the flushed-cycle input never appears.
- Bubble gating: in_valid=0 with mwregin=1, mwmemin=1 -> mwreg=0, mwmem=0 every cycle.
- Forwarding (MEMWB_FWD_EN): beat with mrn=0 and mwreg=1 -> fwd_en=0. Beat with mrn=7, mm2reg=1, di=0xCAFE -> fwd_en=1, fwd_rn=7, fwd_data=0xCAFE.
